// File: rtl/com_bus_sched_rr.sv
// Common-bus scheduler: round-robin processor tenures with snoop and memory grants
// nested inside the owning processor's tenure. All outputs come straight from flops.
module com_bus_sched_rr #(
   parameter int NUM_PROC  = 4,
   parameter int NUM_SNOOP = 4,
   parameter int MAX_HOLD  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PROC-1:0]  Com_Bus_Req_proc,
   input  logic [NUM_SNOOP-1:0] Com_Bus_Req_snoop,
   input  logic                 Mem_snoop_req,
   output logic [NUM_PROC-1:0]  Com_Bus_Gnt_proc,
   output logic [NUM_SNOOP-1:0] Com_Bus_Gnt_snoop,
   output logic                 Mem_snoop_gnt,
   output logic                 Bus_busy,
   output logic                 Hold_timeout
);

   localparam int PPW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
   localparam int SPW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;
   localparam int HW  = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, OWN, SNOOP, MEM} state_t;

   state_t               state, state_nx;
   logic [PPW-1:0]       proc_ptr, proc_ptr_nx, proc_own, proc_own_nx, proc_pick;
   logic [SPW-1:0]       snoop_ptr, snoop_ptr_nx, snoop_own, snoop_own_nx, snoop_pick;
   logic                 proc_hit, snoop_hit;
   logic [HW-1:0]        hold_cnt, hold_cnt_nx;
   logic [NUM_PROC-1:0]  gnt_proc_nx;
   logic [NUM_SNOOP-1:0] gnt_snoop_nx;
   logic                 mem_gnt_nx, timeout_nx;
   logic [PPW-1:0]       proc_own_inc;
   logic [SPW-1:0]       snoop_own_inc;

   // Pointer-order search: scanning offsets high to low leaves the lowest offset as winner.
   always_comb begin
      proc_hit  = 1'b0;
      proc_pick = proc_ptr;
      for (int i = NUM_PROC - 1; i >= 0; i--) begin
         if (Com_Bus_Req_proc[(int'(proc_ptr) + i) % NUM_PROC]) begin
            proc_hit  = 1'b1;
            proc_pick = PPW'((int'(proc_ptr) + i) % NUM_PROC);
         end
      end
      snoop_hit  = 1'b0;
      snoop_pick = snoop_ptr;
      for (int i = NUM_SNOOP - 1; i >= 0; i--) begin
         if (Com_Bus_Req_snoop[(int'(snoop_ptr) + i) % NUM_SNOOP]) begin
            snoop_hit  = 1'b1;
            snoop_pick = SPW'((int'(snoop_ptr) + i) % NUM_SNOOP);
         end
      end
   end

   assign proc_own_inc  = (proc_own == PPW'(NUM_PROC - 1)) ? '0 : proc_own + 1'b1;
   assign snoop_own_inc = (snoop_own == SPW'(NUM_SNOOP - 1)) ? '0 : snoop_own + 1'b1;

   always_comb begin
      state_nx     = state;
      proc_ptr_nx  = proc_ptr;
      proc_own_nx  = proc_own;
      snoop_ptr_nx = snoop_ptr;
      snoop_own_nx = snoop_own;
      gnt_proc_nx  = Com_Bus_Gnt_proc;
      gnt_snoop_nx = Com_Bus_Gnt_snoop;
      mem_gnt_nx   = Mem_snoop_gnt;
      hold_cnt_nx  = hold_cnt;
      if (state != IDLE && hold_cnt != HW'(MAX_HOLD))
         hold_cnt_nx = hold_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (proc_hit) begin
               state_nx               = OWN;
               proc_own_nx            = proc_pick;
               gnt_proc_nx            = '0;
               gnt_proc_nx[proc_pick] = 1'b1;
               hold_cnt_nx            = '0;
            end
         end
         OWN: begin
            if (!Com_Bus_Req_proc[proc_own]) begin
               state_nx    = IDLE;
               gnt_proc_nx = '0;
               proc_ptr_nx = proc_own_inc;
            end else if (snoop_hit) begin
               state_nx                 = SNOOP;
               snoop_own_nx             = snoop_pick;
               gnt_snoop_nx             = '0;
               gnt_snoop_nx[snoop_pick] = 1'b1;
            end else if (Mem_snoop_req) begin
               state_nx   = MEM;
               mem_gnt_nx = 1'b1;
            end
         end
         SNOOP, MEM: begin
            // Nested grant is held until its own request drops; then fall back to the
            // processor tenure, or close it too if the owner has already let go.
            if ((state == SNOOP && !Com_Bus_Req_snoop[snoop_own]) ||
                (state == MEM && !Mem_snoop_req)) begin
               if (state == SNOOP) begin
                  gnt_snoop_nx = '0;
                  snoop_ptr_nx = snoop_own_inc;
               end else begin
                  mem_gnt_nx = 1'b0;
               end
               if (!Com_Bus_Req_proc[proc_own]) begin
                  state_nx    = IDLE;
                  gnt_proc_nx = '0;
                  proc_ptr_nx = proc_own_inc;
               end else begin
                  state_nx = OWN;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      timeout_nx = Hold_timeout | (hold_cnt_nx == HW'(MAX_HOLD));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= IDLE;
         proc_ptr          <= '0;
         proc_own          <= '0;
         snoop_ptr         <= '0;
         snoop_own         <= '0;
         hold_cnt          <= '0;
         Com_Bus_Gnt_proc  <= '0;
         Com_Bus_Gnt_snoop <= '0;
         Mem_snoop_gnt     <= 1'b0;
         Bus_busy          <= 1'b0;
         Hold_timeout      <= 1'b0;
      end else begin
         state             <= state_nx;
         proc_ptr          <= proc_ptr_nx;
         proc_own          <= proc_own_nx;
         snoop_ptr         <= snoop_ptr_nx;
         snoop_own         <= snoop_own_nx;
         hold_cnt          <= hold_cnt_nx;
         Com_Bus_Gnt_proc  <= gnt_proc_nx;
         Com_Bus_Gnt_snoop <= gnt_snoop_nx;
         Mem_snoop_gnt     <= mem_gnt_nx;
         Bus_busy          <= (state_nx != IDLE);
         Hold_timeout      <= timeout_nx;
      end
   end

endmodule
